// File: rtl/ascon_permutation.sv
// rtl/ascon_permutation.sv - Ascon p6/p12 permutation, one round per clock
// Define ASCON_PERM_UNROLL2_EN to apply two rounds per clock.
module ascon_permutation (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [3:0]   nb_rounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

`ifdef ASCON_PERM_UNROLL2_EN
    localparam logic [3:0] RC_STEP = 4'd2;
`else
    localparam logic [3:0] RC_STEP = 4'd1;
`endif

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [3:0]   rc_q;
    logic [319:0] state_q;
    logic         done_q;
    logic         last_round;
    logic         accept;
    logic [319:0] round_out;

    // Constants run 0xf0, 0xe1, ... 0x4b: upper nibble counts down as rc counts up.
    function automatic logic [7:0] round_const(input logic [3:0] rc);
        return {4'hf - rc, rc};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] rc);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, round_const(rc)};
        x3 = s[127:64];
        x4 = s[63:0];
        // Bitsliced form of the 5-bit S-box, all 64 columns in parallel.
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

`ifdef ASCON_PERM_UNROLL2_EN
    // rc always starts even (0 or 6), so the pair (rc, rc+1) never runs past 11.
    assign round_out  = ascon_round(ascon_round(state_q, rc_q), rc_q + 4'd1);
    assign last_round = (rc_q >= 4'd10);
`else
    assign round_out  = ascon_round(state_q, rc_q);
    assign last_round = (rc_q >= 4'd11);
`endif

    assign accept  = (fsm_q == IDLE) && start_i;
    assign state_o = state_q;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start_i) fsm_d = RUN;
            RUN:     if (last_round) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (fsm_q == RUN);
        done_o = done_q;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= '0;
            rc_q    <= '0;
            done_q  <= 1'b0;
        end else if (accept) begin
            state_q <= state_i;
            rc_q    <= (nb_rounds_i == 4'd6) ? 4'd6 : 4'd0;
            done_q  <= 1'b0;
        end else if (fsm_q == RUN) begin
            state_q <= round_out;
            rc_q    <= rc_q + RC_STEP;
            done_q  <= last_round;
        end else begin
            done_q  <= 1'b0;
        end
    end

endmodule
